// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start/data/parity/stop bits around
// an external serializer, computes parity at accept and cross-checks ser_done.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  sync_err
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] W_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] W_DONE_AT = CW'(DATA_WIDTH - 2);
  localparam logic W_STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic          r_stop_cnt, w_stop_cnt_nxt;
  logic          r_par_bit, r_par_en_q, r_sync_err;
  logic          w_accept, w_sync_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_bit  <= 1'b0;
      r_par_en_q <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_sync_err <= w_sync_err;
      if (w_accept) begin
        r_par_bit  <= (^P_DATA) ^ PAR_TYP;
        r_par_en_q <= PAR_EN;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_accept       = 1'b0;
    w_sync_err     = 1'b0;
    ser_en         = 1'b0;
    TX_OUT         = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (Data_Valid) begin
          w_accept = 1'b1;
          w_next   = S_START;
        end
      end
      S_START: begin
        TX_OUT        = 1'b0;
        ser_en        = 1'b1;
        w_sync_err    = ser_done;
        w_bit_cnt_nxt = '0;
        w_next        = S_DATA;
      end
      S_DATA: begin
        TX_OUT     = ser_data;
        ser_en     = (r_bit_cnt < W_LAST);
        // serializer raises done one bit early because its output is registered
        w_sync_err = ser_done ^ (r_bit_cnt == W_DONE_AT);
        if (r_bit_cnt == W_LAST) begin
          w_bit_cnt_nxt = '0;
          w_next        = r_par_en_q ? S_PARITY : S_STOP;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        TX_OUT = r_par_bit;
        w_next = S_STOP;
      end
      S_STOP: begin
        if (r_stop_cnt == W_STOP_LAST) begin
          w_stop_cnt_nxt = 1'b0;
          w_next         = S_IDLE;
        end else begin
          w_stop_cnt_nxt = r_stop_cnt + 1'b1;
        end
      end
      default: begin
        w_next         = S_IDLE;
        w_bit_cnt_nxt  = '0;
        w_stop_cnt_nxt = 1'b0;
      end
    endcase
  end

  assign busy     = (r_state != S_IDLE);
  assign sync_err = r_sync_err;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: one instance per stop-bit setting, each
// paired with a behavioural serializer; expected frames are built as bit queues.
module tb_uart_tx_ctrl;
  localparam int DW = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       dv    [2];
  logic       fd    [2];
  logic       sdone [2];
  logic       sdata [2];
  logic       mdone [2];
  logic       sen   [2];
  logic       bsy   [2];
  logic       tx    [2];
  logic       serr  [2];
  logic [7:0] sh    [2];
  int         cnt   [2];
  logic [7:0] P_DATA;
  logic       PAR_EN, PAR_TYP;
  int         checks = 0;
  int         errors = 0;

  always #5 CLK = ~CLK;

  assign sdone[0] = mdone[0] | fd[0];
  assign sdone[1] = mdone[1] | fd[1];

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .Data_Valid(dv[0]), .P_DATA(P_DATA), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .ser_done(sdone[0]), .ser_data(sdata[0]), .ser_en(sen[0]),
    .busy(bsy[0]), .TX_OUT(tx[0]), .sync_err(serr[0]));

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .Data_Valid(dv[1]), .P_DATA(P_DATA), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .ser_done(sdone[1]), .ser_data(sdata[1]), .ser_en(sen[1]),
    .busy(bsy[1]), .TX_OUT(tx[1]), .sync_err(serr[1]));

  // Serializer stand-in: loads on accept, registered LSB-first shift on ser_en,
  // done flag high while the 7th shifted bit is on its output.
  always @(posedge CLK or negedge RST) begin
    for (int i = 0; i < 2; i++) begin
      if (!RST) begin
        sh[i] <= '0; sdata[i] <= 1'b0; cnt[i] <= 0; mdone[i] <= 1'b0;
      end else if (dv[i] && !bsy[i]) begin
        sh[i] <= P_DATA; cnt[i] <= 0; mdone[i] <= 1'b0;
      end else if (sen[i]) begin
        sdata[i] <= sh[i][0];
        sh[i]    <= sh[i] >> 1;
        mdone[i] <= (cnt[i] == DW - 2);
        cnt[i]   <= cnt[i] + 1;
      end else begin
        mdone[i] <= 1'b0;
      end
    end
  end

  function automatic int stop_bits(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d);
    chk($sformatf("idle_tx%0d", d), 32'(tx[d]), 32'd1);
    chk($sformatf("idle_busy%0d", d), 32'(bsy[d]), 32'd0);
    chk($sformatf("idle_ser_en%0d", d), 32'(sen[d]), 32'd0);
    chk($sformatf("idle_sync_err%0d", d), 32'(serr[d]), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      chk_idle(0);
      chk_idle(1);
    end
  endtask

  // Drives one frame on instance d and checks every bit time of it.
  // keep: hold Data_Valid high and scramble the inputs throughout the frame.
  // force_k / abort_k: frame cycle (0 = start bit) in which to force ser_done or pulse reset.
  task automatic send(input int d, input logic [7:0] data, input logic pe, input logic pt,
                      input bit keep, input int force_k, input int abort_k);
    logic q[$];
    int   ones;
    dv[d] = 1'b1; P_DATA = data; PAR_EN = pe; PAR_TYP = pt;
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(data[i]);
    ones = $countones(data);
    if (pe) q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    for (int s = 0; s < stop_bits(d); s++) q.push_back(1'b1);
    @(posedge CLK); #1;
    if (!keep) dv[d] = 1'b0;
    P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    for (int k = 0; k < q.size(); k++) begin
      fd[d] = (k == force_k);
      chk($sformatf("tx%0d_k%0d", d, k), 32'(tx[d]), 32'(q[k]));
      chk($sformatf("busy%0d_k%0d", d, k), 32'(bsy[d]), 32'd1);
      chk($sformatf("ser_en%0d_k%0d", d, k), 32'(sen[d]), 32'(k < DW));
      chk($sformatf("sync_err%0d_k%0d", d, k), 32'(serr[d]),
          32'(force_k >= 0 && k == force_k + 1));
      if (k == abort_k) begin
        RST = 1'b0; #1;
        chk_idle(d);
        fd[d] = 1'b0; dv[d] = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        return;
      end
      @(posedge CLK); #1;
      if (keep) begin
        P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      end
    end
    fd[d] = 1'b0;
    chk_idle(d);
  endtask

  initial begin
    dv[0] = 1'b0; dv[1] = 1'b0; fd[0] = 1'b0; fd[1] = 1'b0;
    P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #2;
    chk_idle(0);
    chk_idle(1);
    @(negedge CLK);
    RST = 1'b1;
    idle(5);

    send(0, 8'hA5, 1'b1, 1'b0, 1'b0, -1, -1);
    idle(1);
    send(0, 8'hA5, 1'b1, 1'b1, 1'b0, -1, -1);
    send(0, 8'h01, 1'b0, 1'b0, 1'b0, -1, -1);
    idle(2);

    send(0, 8'h3C, 1'b1, 1'b0, 1'b1, -1, -1);
    send(0, 8'hC3, 1'b1, 1'b0, 1'b0, -1, -1);
    idle(1);
    send(1, 8'h3C, 1'b1, 1'b1, 1'b1, -1, -1);
    send(1, 8'hC3, 1'b0, 1'b0, 1'b0, -1, -1);
    idle(1);

    send(0, 8'h5A, 1'b1, 1'b0, 1'b0, -1, 4);
    idle(4);
    send(1, 8'h69, 1'b1, 1'b1, 1'b0, -1, 4);
    idle(4);

    send(0, 8'h96, 1'b1, 1'b1, 1'b0, 3, -1);
    send(1, 8'h0F, 1'b0, 1'b0, 1'b0, 3, -1);
    idle(1);

    repeat (24) begin
      send(int'($urandom_range(1, 0)), 8'($urandom), 1'($urandom), 1'($urandom),
           1'b0, -1, -1);
      idle(int'($urandom_range(2, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
